// File: rtl/dual_modulus_counter.sv
// Dual-modulus up/down counter (MOD_A or MOD_B by mode) with load, a
// registered terminal-count pulse z and a saturating wrap-event count.
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   en       count enable
//   mode     modulus select (0: MOD_A, 1: MOD_B)
//   dir      direction (0: up, 1: down)
//   load     synchronous load strobe, has priority over en
//   load_val value to load, saturated to M-1
//   cnt      registered count
//   z        registered one-cycle terminal-count pulse
//   wraps    saturating count of wrap events, cleared only by rst
module dual_modulus_counter #(
    parameter int WIDTH  = 4,
    parameter int MOD_A  = 2,
    parameter int MOD_B  = 4,
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic              dir,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    output logic [WIDTH-1:0]  cnt,
    output logic              z,
    output logic [WRAP_W-1:0] wraps
);

    if (MOD_A < 2 || MOD_A > (1 << WIDTH) ||
        MOD_B < 2 || MOD_B > (1 << WIDTH)) begin : g_bad_param
        $error("dual_modulus_counter: MOD_A/MOD_B outside 2..2**WIDTH");
    end

    // M-1 always fits in WIDTH bits because M <= 2**WIDTH.
    localparam logic [WIDTH-1:0]  TOP_A    = WIDTH'(MOD_A - 1);
    localparam logic [WIDTH-1:0]  TOP_B    = WIDTH'(MOD_B - 1);
    localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

    logic [WIDTH-1:0]  top;
    logic [WIDTH-1:0]  cnt_nxt;
    logic              z_nxt;
    logic [WRAP_W-1:0] wraps_nxt;

    assign top = mode ? TOP_B : TOP_A;

    always_comb begin
        cnt_nxt   = cnt;
        z_nxt     = 1'b0;
        wraps_nxt = wraps;
        if (load) begin
            cnt_nxt = (load_val > top) ? top : load_val;
        end else if (en) begin
            if (!dir) begin
                // At or beyond the top (possible after a mode switch)
                // an up step wraps to zero.
                if (cnt >= top) begin
                    cnt_nxt = '0;
                    z_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt + WIDTH'(1);
                end
            end else begin
                if (cnt == '0) begin
                    cnt_nxt = top;
                    z_nxt   = 1'b1;
                end else if (cnt > top) begin
                    // Range recovery after a mode switch, not a wrap.
                    cnt_nxt = top;
                end else begin
                    cnt_nxt = cnt - WIDTH'(1);
                end
            end
        end
        if (z_nxt && wraps != WRAP_MAX) begin
            wraps_nxt = wraps + WRAP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            z     <= 1'b0;
            wraps <= '0;
        end else begin
            cnt   <= cnt_nxt;
            z     <= z_nxt;
            wraps <= wraps_nxt;
        end
    end

endmodule

// File: doc/dual_modulus_counter.md
Name: dual_modulus_counter

Overview:
- Parametrised successor to the team's two/four mode counter.
- Counts modulo MOD_A or MOD_B, chosen by the mode input, with enable, up/down direction, synchronous load and a registered terminal-count pulse.
- Keeps a saturating count of wrap events.
- Used as the general-purpose sequence/divider element in lab datapaths and as a drop-in for fixed 2/4 counters.

Parameters:
- WIDTH, 4: counter width in bits. Requires 2^WIDTH >= max(MOD_A, MOD_B).
- MOD_A, 2: modulus when mode=0. Legal range 2..2^WIDTH.
- MOD_B, 4: modulus when mode=1. Legal range 2..2^WIDTH.
- WRAP_W, 8: width of the wrap-event counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable. Step on the edge where en=1.
- mode  input  1  modulus select: 0 = MOD_A, 1 = MOD_B. Sampled every edge.
- dir  input  1  direction: 0 = up, 1 = down.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value to load.
- cnt  output  WIDTH  registered count.
- z  output  1  registered terminal-count pulse.
- wraps  output  WRAP_W  saturating wrap-event count.

Behaviour:
- Reset: synchronous, active-high (rst=1 at a clk rising edge). Outputs after that edge: cnt=0, z=0, wraps=0. Reset wins over all other inputs, including mid-count and mid-load.
- M = mode ? MOD_B : MOD_A. M is evaluated from the mode value at the same edge.
- Priority: rst > load > en. The dir and mode inputs matter only when en or load acts.
- Load (load=1): cnt <= min(load_val, M-1), i.e. out-of-range values saturate to M-1. z <= 0. wraps is unchanged. en is ignored on that edge.
- Up step (en=1, dir=0):
  - cnt == M-1: cnt <= 0, z <= 1.
  - cnt > M-1 (out of range after a mode switch): cnt <= 0, z <= 1.
  - otherwise: cnt <= cnt+1, z <= 0.
- Down step (en=1, dir=1):
  - cnt == 0: cnt <= M-1, z <= 1.
  - cnt > M-1: cnt <= M-1, z <= 0. This is range recovery, not a wrap.
  - otherwise: cnt <= cnt-1, z <= 0.
- Idle (en=0, load=0, rst=0): cnt holds, z <= 0. An out-of-range cnt left by a mode switch is held unchanged until the next step or load.
- z timing:
  - z is high for exactly one cycle, coincident with the wrapped cnt value (latency 1 from the stepping edge).
  - Back-to-back wraps are legal: e.g. M=2, up, en=1 continuously gives z high every second cycle.
- wraps: increments on every edge where z is being set to 1. Saturates at 2^WRAP_W-1 with no rollover. Cleared only by rst; load does not clear it.
- Mode or direction change: takes effect on the same edge; no pipeline delay and no extra z pulse on the change itself.
- All outputs are registers; there is no combinational path from inputs to outputs.
- Illegal parameters (MOD_x < 2 or > 2^WIDTH) are a synthesis-time error, enforced by a generate-time check.

Test Plan:
- rst=1 for 2 cycles, then en=1, mode=0, dir=0 for 6 cycles -> cnt = 1,0,1,0,1,0; z=1 on each cnt=0 cycle; wraps=3.
- mode=1, dir=0, en=1 from cnt=0 for 8 cycles -> cnt = 1,2,3,0,1,2,3,0; z on both cnt=0 cycles; wraps +2.
- mode=1, cnt=3; switch mode=0 with en=0 for 2 cycles -> cnt holds 3, z=0. Then en=1, dir=0 -> cnt=0, z=1. Repeat from cnt=3 with dir=1 -> cnt=1, z=0.
- mode=1, dir=1, en=1 from cnt=0 -> cnt = 3,2,1,0,3 with z=1 on the first and last steps. Then load=1, load_val=9 with en=1 -> cnt=3, z=0.
- Mid-count (cnt=2, z just pulsed): rst=1 together with load=1, en=1 -> cnt=0, z=0, wraps=0 on the next cycle.
- Parameter override WIDTH=3, MOD_A=8, MOD_B=5, WRAP_W=2: run 40 up steps with mode=0 -> wraps saturates at 3 and stays 3.
